dll_tx_arb: RTL and testbench

- Parametrised transmit-side arbiter for the data link layer.
- Merges one TLP beat stream (from the retry/sequence path) with NUM_SRC independent DLLP request sources (Ack/Nak, UpdateFC P/NP/CPL) onto the single PIPE transmit port.
- Never splits a TLP. Gives DLLPs priority between packets, with a starvation guard for TLPs and round-robin fairness among DLLP sources.
- Output is registered with full valid/ready backpressure from the PIPE side.

---
 rtl/dll_tx_arb.sv | 167 ++++++++++++++++
 tb/tb_dll_tx_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_tx_arb.sv
// dll_tx_arb: data link layer transmit arbiter.
// Merges one TLP beat stream with NUM_SRC single-beat DLLP sources onto the
// PIPE transmit port. TLPs are never split; DLLPs win between packets, with a
// starvation guard for a waiting TLP and round-robin among DLLP sources.
// Output is a single registered slot with valid/ready backpressure.
module dll_tx_arb #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int NUM_SRC         = 4,
  parameter int STARVE_LIMIT    = 4,
  parameter int TLP_MAX_BEATS   = 16
) (
  input  logic                       sclk,
  input  logic                       srst_n,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  input  logic                       tlp_valid_i,
  input  logic                       tlp_sop_i,
  input  logic                       tlp_eop_i,
  output logic                       tlp_ready_o,
  input  logic [NUM_SRC*64-1:0]      dllp_data_i,
  input  logic [NUM_SRC-1:0]         dllp_valid_i,
  output logic [NUM_SRC-1:0]         dllp_ready_o,
  output logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o,
  output logic                       pipe_txvalid_o,
  input  logic                       pipe_txready_i,
  output logic                       grant_tlp_o,
  output logic                       tlp_len_err_o
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(TLP_MAX_BEATS + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_TLP  = 1'b1;

  logic [0:0]                 state;
  logic [PW-1:0]              rr_ptr;
  logic [CW-1:0]              starve_cnt;
  logic [BW-1:0]              beat_cnt;

  logic                       slot_free;
  logic                       sop_pend;
  logic                       starve_hold;
  logic                       rr_hit;
  logic [PW-1:0]              rr_sel;
  logic                       dllp_gnt;
  logic                       tlp_acc;
  logic                       tlp_fwd;
  logic                       tlp_drop;
  logic [BW-1:0]              new_cnt;
  logic                       hit_max;
  logic                       len_err;
  logic [PIPE_DATA_WIDTH-1:0] dllp_beat;

  assign slot_free   = !pipe_txvalid_o || pipe_txready_i;
  assign sop_pend    = tlp_valid_i && tlp_sop_i;
  assign starve_hold = (starve_cnt == CW'(STARVE_LIMIT)) && sop_pend;

  // Round-robin search: first requesting source at or after the pointer.
  always_comb begin
    int idx;
    idx    = 0;
    rr_hit = 1'b0;
    rr_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_SRC;
      if (!rr_hit && dllp_valid_i[idx]) begin
        rr_hit = 1'b1;
        rr_sel = PW'(idx);
      end
    end
  end

  // Arbitration: nothing moves unless the output slot can take a beat.
  // In IDLE a DLLP wins unless the starvation guard forces the TLP through;
  // any TLP beat reaching IDLE without sop is accepted only to be dropped.
  always_comb begin
    dllp_gnt = 1'b0;
    tlp_acc  = 1'b0;
    if (slot_free) begin
      if (state == S_TLP)
        tlp_acc = tlp_valid_i;
      else if (rr_hit && !starve_hold)
        dllp_gnt = 1'b1;
      else
        tlp_acc = tlp_valid_i;
    end
  end

  assign tlp_fwd  = tlp_acc && ((state == S_TLP) || tlp_sop_i);
  assign tlp_drop = tlp_acc && !tlp_fwd;
  assign new_cnt  = tlp_sop_i ? BW'(1) : beat_cnt + 1'b1;
  assign hit_max  = tlp_fwd && !tlp_eop_i && (new_cnt == BW'(TLP_MAX_BEATS));
  // Errors: orphan beat in IDLE, sop truncating a packet, or overlong packet.
  assign len_err  = tlp_drop || (tlp_acc && (state == S_TLP) && tlp_sop_i) || hit_max;

  assign tlp_ready_o = tlp_acc;

  // One-hot accept for the granted DLLP source.
  always_comb begin
    dllp_ready_o         = '0;
    dllp_ready_o[rr_sel] = dllp_gnt;
  end

  // DLLP occupies the low 8 bytes of the beat, rest zero.
  always_comb begin
    dllp_beat       = '0;
    dllp_beat[63:0] = dllp_data_i[int'(rr_sel)*64 +: 64];
  end

  // Packet FSM and beat counter; an overlong packet is closed so that its
  // tail is dropped as orphan beats until the next sop.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else if (tlp_fwd) begin
      beat_cnt <= new_cnt;
      state    <= (tlp_eop_i || hit_max) ? S_IDLE : S_TLP;
    end
  end

  // Round-robin pointer moves past the source just granted.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n)
      rr_ptr <= '0;
    else if (dllp_gnt)
      rr_ptr <= (rr_sel == PW'(NUM_SRC - 1)) ? '0 : rr_sel + 1'b1;
  end

  // Starvation counter: counts DLLP grants that pass over a waiting TLP sop.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n)
      starve_cnt <= '0;
    else if (slot_free) begin
      if ((tlp_fwd && tlp_sop_i) || !sop_pend)
        starve_cnt <= '0;
      else if (dllp_gnt && (starve_cnt != CW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Output slot: loads only when free, holds everything while stalled.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      pipe_txvalid_o <= 1'b0;
      pipe_txdata_o  <= '0;
      grant_tlp_o    <= 1'b0;
    end else if (slot_free) begin
      pipe_txvalid_o <= tlp_fwd || dllp_gnt;
      grant_tlp_o    <= tlp_fwd;
      if (tlp_fwd)
        pipe_txdata_o <= tlp_data_i;
      else if (dllp_gnt)
        pipe_txdata_o <= dllp_beat;
    end
  end

  // Length error is a single-cycle pulse, aligned with the offending beat.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n)
      tlp_len_err_o <= 1'b0;
    else
      tlp_len_err_o <= len_err;
  end

endmodule

// File: tb/tb_dll_tx_arb.sv
// Directed bench for dll_tx_arb with default parameters (256/4/4/16).
// Inputs change on the falling edge; registered outputs are sampled on the
// falling edge, combinational readies #1 after the inputs change.
module tb_dll_tx_arb;

  localparam int W  = 256;
  localparam int NS = 4;

  logic          sclk;
  logic          srst_n;
  logic [W-1:0]  tlp_data_i;
  logic          tlp_valid_i;
  logic          tlp_sop_i;
  logic          tlp_eop_i;
  logic          tlp_ready_o;
  logic [NS*64-1:0] dllp_data_i;
  logic [NS-1:0] dllp_valid_i;
  logic [NS-1:0] dllp_ready_o;
  logic [W-1:0]  pipe_txdata_o;
  logic          pipe_txvalid_o;
  logic          pipe_txready_i;
  logic          grant_tlp_o;
  logic          tlp_len_err_o;

  int passed = 0;
  int total  = 0;

  dll_tx_arb #(.PIPE_DATA_WIDTH(W), .NUM_SRC(NS), .STARVE_LIMIT(4), .TLP_MAX_BEATS(16)) dut (
    .sclk(sclk), .srst_n(srst_n),
    .tlp_data_i(tlp_data_i), .tlp_valid_i(tlp_valid_i), .tlp_sop_i(tlp_sop_i),
    .tlp_eop_i(tlp_eop_i), .tlp_ready_o(tlp_ready_o),
    .dllp_data_i(dllp_data_i), .dllp_valid_i(dllp_valid_i), .dllp_ready_o(dllp_ready_o),
    .pipe_txdata_o(pipe_txdata_o), .pipe_txvalid_o(pipe_txvalid_o),
    .pipe_txready_i(pipe_txready_i), .grant_tlp_o(grant_tlp_o),
    .tlp_len_err_o(tlp_len_err_o)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic logic [W-1:0] tbeat(input int n);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(n);
    return {(W/32){w}};
  endfunction

  function automatic logic [63:0] dword(input int k);
    return 64'hD11F_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [W-1:0] dexp(input int k);
    logic [W-1:0] v;
    v       = '0;
    v[63:0] = dword(k);
    return v;
  endfunction

  task automatic drive_tlp(input logic v, input logic s, input logic e, input int n);
    tlp_valid_i = v;
    tlp_sop_i   = s;
    tlp_eop_i   = e;
    tlp_data_i  = tbeat(n);
  endtask

  task automatic apply_reset;
    srst_n         = 1'b0;
    drive_tlp(1'b0, 1'b0, 1'b0, 0);
    dllp_valid_i   = '0;
    pipe_txready_i = 1'b1;
    repeat (2) @(negedge sclk);
    srst_n = 1'b1;
  endtask

  task automatic test_reset;
    srst_n = 1'b0;
    drive_tlp(1'b0, 1'b0, 1'b0, 0);
    dllp_valid_i   = '0;
    pipe_txready_i = 1'b1;
    @(negedge sclk);
    #1;
    total++;
    if (pipe_txvalid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", pipe_txvalid_o);
    else passed++;
    @(negedge sclk);
    srst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sclk);
      total++;
      if ({pipe_txvalid_o, grant_tlp_o, tlp_len_err_o, tlp_ready_o} !== 4'b0000 ||
          dllp_ready_o !== 4'b0000 || pipe_txdata_o !== '0)
        $display("FAIL idle_c%0d got v/g/e/tr=%b%b%b%b dr=%b exp all 0", c,
                 pipe_txvalid_o, grant_tlp_o, tlp_len_err_o, tlp_ready_o, dllp_ready_o);
      else passed++;
    end
  endtask

  task automatic test_tlp_then_dllp;
    @(negedge sclk);
    drive_tlp(1'b1, 1'b1, 1'b0, 1);
    #1;
    total++;
    if (tlp_ready_o !== 1'b1) $display("FAIL td_rdy0 got=%b exp=1", tlp_ready_o);
    else passed++;
    for (int b = 1; b <= 3; b++) begin
      @(negedge sclk);
      total++;
      if ({pipe_txvalid_o, grant_tlp_o} !== 2'b11 || pipe_txdata_o !== tbeat(b))
        $display("FAIL td_beat%0d got v/g=%b%b d=%h exp 11 d=%h", b,
                 pipe_txvalid_o, grant_tlp_o, pipe_txdata_o, tbeat(b));
      else passed++;
      dllp_valid_i = 4'b0001;
      if (b < 3) drive_tlp(1'b1, 1'b0, b == 2, b + 1);
      else       drive_tlp(1'b0, 1'b0, 1'b0, 0);
      #1;
      total++;
      if (b < 3 && {tlp_ready_o, dllp_ready_o} !== 5'b1_0000)
        $display("FAIL td_rdy%0d got tr=%b dr=%b exp tr=1 dr=0000", b, tlp_ready_o, dllp_ready_o);
      else if (b == 3 && {tlp_ready_o, dllp_ready_o} !== 5'b0_0001)
        $display("FAIL td_rdy%0d got tr=%b dr=%b exp tr=0 dr=0001", b, tlp_ready_o, dllp_ready_o);
      else passed++;
    end
    @(negedge sclk);
    dllp_valid_i = '0;
    total++;
    if ({pipe_txvalid_o, grant_tlp_o} !== 2'b10 || pipe_txdata_o !== dexp(0))
      $display("FAIL td_dllp got v/g=%b%b d=%h exp 10 d=%h",
               pipe_txvalid_o, grant_tlp_o, pipe_txdata_o, dexp(0));
    else passed++;
    @(negedge sclk);
    total++;
    if (pipe_txvalid_o !== 1'b0) $display("FAIL td_drain got=%b exp=0", pipe_txvalid_o);
    else passed++;
  endtask

  task automatic test_round_robin;
    apply_reset();
    @(negedge sclk);
    dllp_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (dllp_ready_o !== 4'(1 << (i % 4)) || tlp_ready_o !== 1'b0)
        $display("FAIL rr_rdy%0d got dr=%b tr=%b exp dr=%b tr=0", i, dllp_ready_o,
                 tlp_ready_o, 4'(1 << (i % 4)));
      else passed++;
      @(negedge sclk);
      total++;
      if ({pipe_txvalid_o, grant_tlp_o} !== 2'b10 || pipe_txdata_o !== dexp(i % 4))
        $display("FAIL rr_out%0d got v/g=%b%b d=%h exp 10 d=%h", i,
                 pipe_txvalid_o, grant_tlp_o, pipe_txdata_o, dexp(i % 4));
      else passed++;
    end
    dllp_valid_i = '0;
    @(negedge sclk);
    total++;
    if (pipe_txvalid_o !== 1'b0) $display("FAIL rr_drain got=%b exp=0", pipe_txvalid_o);
    else passed++;
  endtask

  task automatic test_starvation;
    int g[7];
    g = '{0, 1, 2, 3, -1, 0, 1};
    apply_reset();
    @(negedge sclk);
    dllp_valid_i = 4'b1111;
    drive_tlp(1'b1, 1'b1, 1'b1, 7);
    for (int c = 0; c < 7; c++) begin
      #1;
      total++;
      if (g[c] < 0 && {tlp_ready_o, dllp_ready_o} !== 5'b1_0000)
        $display("FAIL st_rdy%0d got tr=%b dr=%b exp tr=1 dr=0000", c, tlp_ready_o, dllp_ready_o);
      else if (g[c] >= 0 && {tlp_ready_o, dllp_ready_o} !== {1'b0, 4'(1 << g[c])})
        $display("FAIL st_rdy%0d got tr=%b dr=%b exp tr=0 dr=%b", c, tlp_ready_o,
                 dllp_ready_o, 4'(1 << g[c]));
      else passed++;
      @(negedge sclk);
      if (c == 4) drive_tlp(1'b0, 1'b0, 1'b0, 0);
      total++;
      if (g[c] < 0 && ({pipe_txvalid_o, grant_tlp_o} !== 2'b11 || pipe_txdata_o !== tbeat(7)))
        $display("FAIL st_out%0d got v/g=%b%b d=%h exp tlp", c, pipe_txvalid_o, grant_tlp_o, pipe_txdata_o);
      else if (g[c] >= 0 && ({pipe_txvalid_o, grant_tlp_o} !== 2'b10 || pipe_txdata_o !== dexp(g[c])))
        $display("FAIL st_out%0d got v/g=%b%b d=%h exp dllp src%0d", c,
                 pipe_txvalid_o, grant_tlp_o, pipe_txdata_o, g[c]);
      else passed++;
    end
    dllp_valid_i = '0;
    @(negedge sclk);
    total++;
    if (pipe_txvalid_o !== 1'b0) $display("FAIL st_drain got=%b exp=0", pipe_txvalid_o);
    else passed++;
  endtask

  task automatic test_backpressure;
    apply_reset();
    @(negedge sclk);
    drive_tlp(1'b1, 1'b1, 1'b0, 10);
    #1;
    total++;
    if (tlp_ready_o !== 1'b1) $display("FAIL bp_rdy0 got=%b exp=1", tlp_ready_o);
    else passed++;
    @(negedge sclk);
    total++;
    if ({pipe_txvalid_o, grant_tlp_o} !== 2'b11 || pipe_txdata_o !== tbeat(10))
      $display("FAIL bp_b10 got v/g=%b%b d=%h", pipe_txvalid_o, grant_tlp_o, pipe_txdata_o);
    else passed++;
    drive_tlp(1'b1, 1'b0, 1'b0, 11);
    @(negedge sclk);
    pipe_txready_i = 1'b0;
    drive_tlp(1'b1, 1'b0, 1'b0, 12);
    for (int c = 0; c < 6; c++) begin
      total++;
      if ({pipe_txvalid_o, grant_tlp_o} !== 2'b11 || pipe_txdata_o !== tbeat(11))
        $display("FAIL bp_hold%0d got v/g=%b%b d=%h exp beat 11", c,
                 pipe_txvalid_o, grant_tlp_o, pipe_txdata_o);
      else passed++;
      if (c == 5) pipe_txready_i = 1'b1;
      #1;
      total++;
      if (tlp_ready_o !== (c == 5)) $display("FAIL bp_rdy_c%0d got=%b exp=%b", c, tlp_ready_o, c == 5);
      else passed++;
      @(negedge sclk);
    end
    total++;
    if ({pipe_txvalid_o, grant_tlp_o} !== 2'b11 || pipe_txdata_o !== tbeat(12))
      $display("FAIL bp_b12 got v/g=%b%b d=%h", pipe_txvalid_o, grant_tlp_o, pipe_txdata_o);
    else passed++;
    drive_tlp(1'b1, 1'b0, 1'b1, 13);
    @(negedge sclk);
    total++;
    if ({pipe_txvalid_o, grant_tlp_o} !== 2'b11 || pipe_txdata_o !== tbeat(13))
      $display("FAIL bp_b13 got v/g=%b%b d=%h", pipe_txvalid_o, grant_tlp_o, pipe_txdata_o);
    else passed++;
    drive_tlp(1'b0, 1'b0, 1'b0, 0);
    @(negedge sclk);
    total++;
    if (pipe_txvalid_o !== 1'b0) $display("FAIL bp_drain got=%b exp=0", pipe_txvalid_o);
    else passed++;
  endtask

  task automatic test_len_err;
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge sclk);
      if (i > 1) begin
        total++;
        if ({pipe_txvalid_o, grant_tlp_o, tlp_len_err_o} !== {2'b11, i - 1 == 16} ||
            pipe_txdata_o !== tbeat(100 + i - 1))
          $display("FAIL le_beat%0d got v/g/e=%b%b%b exp 11%b", i - 1,
                   pipe_txvalid_o, grant_tlp_o, tlp_len_err_o, i - 1 == 16);
        else passed++;
      end
      drive_tlp(1'b1, i == 1, 1'b0, 100 + i);
      #1;
      total++;
      if (tlp_ready_o !== 1'b1) $display("FAIL le_rdy%0d got=%b exp=1", i, tlp_ready_o);
      else passed++;
    end
    @(negedge sclk);
    total++;
    if ({pipe_txvalid_o, tlp_len_err_o} !== 2'b01)
      $display("FAIL le_drop17 got v/e=%b%b exp 01", pipe_txvalid_o, tlp_len_err_o);
    else passed++;
    drive_tlp(1'b0, 1'b0, 1'b0, 0);
    @(negedge sclk);
    total++;
    if ({pipe_txvalid_o, tlp_len_err_o} !== 2'b00)
      $display("FAIL le_quiet got v/e=%b%b exp 00", pipe_txvalid_o, tlp_len_err_o);
    else passed++;
  endtask

  task automatic test_reset_mid_packet;
    apply_reset();
    @(negedge sclk);
    drive_tlp(1'b1, 1'b1, 1'b0, 50);
    @(negedge sclk);
    drive_tlp(1'b1, 1'b0, 1'b0, 51);
    total++;
    if ({pipe_txvalid_o, grant_tlp_o} !== 2'b11)
      $display("FAIL rm_pre got v/g=%b%b exp 11", pipe_txvalid_o, grant_tlp_o);
    else passed++;
    #2 srst_n = 1'b0;
    #1;
    total++;
    if ({pipe_txvalid_o, grant_tlp_o} !== 2'b00)
      $display("FAIL rm_async got v/g=%b%b exp 00", pipe_txvalid_o, grant_tlp_o);
    else passed++;
    @(negedge sclk);
    srst_n = 1'b1;
    drive_tlp(1'b1, 1'b0, 1'b0, 52);
    @(negedge sclk);
    total++;
    if ({pipe_txvalid_o, tlp_len_err_o} !== 2'b01)
      $display("FAIL rm_idle_drop got v/e=%b%b exp 01", pipe_txvalid_o, tlp_len_err_o);
    else passed++;
    drive_tlp(1'b0, 1'b0, 1'b0, 0);
    @(negedge sclk);
  endtask

  initial begin
    for (int k = 0; k < NS; k++) dllp_data_i[k*64 +: 64] = dword(k);
    test_reset();
    test_tlp_then_dllp();
    test_round_robin();
    test_starvation();
    test_backpressure();
    test_len_err();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
